// File: rtl/fifo_read_streamer.sv
`default_nettype none
// ============================================================================
// Module  : fifo_read_streamer
// Brief   : Async-FIFO read-side consumer feeding a framed valid/ready stream
//           through a 2-entry buffer.
// Revision: 1.0
// ============================================================================
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  enable,
  input  logic                  rempty,
  output logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] data_read,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  busy
);

  localparam int               IDX_W      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(PKT_LEN - 1);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_WIDTH-1:0]  r_pkt_count;

  logic                  w_pop;
  logic [2:0]            w_occ_next;
  logic [1:0]            w_occ_after_pop;
  logic [DATA_WIDTH-1:0] w_buf0_next;
  logic [DATA_WIDTH-1:0] w_buf1_next;

  assign m_valid         = (r_occ != 2'd0);
  assign m_data          = r_buf0;
  assign m_last          = m_valid & (r_idx == C_IDX_LAST);
  assign w_pop           = m_valid & m_ready;
  assign w_occ_next      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};
  // m_ready reaches read_enable combinationally so a full buffer can still
  // sustain one word per cycle.
  assign read_enable     = rrst_n & enable & ~rempty & (w_occ_next < 3'd2);
  assign busy            = m_valid | r_inflight;
  assign pkt_count       = r_pkt_count;

  // Pop shifts the tail to the head; the arriving word lands in the first free slot.
  always_comb begin
    w_buf0_next = w_pop ? r_buf1 : r_buf0;
    w_buf1_next = r_buf1;
    if (r_inflight) begin
      if (w_occ_after_pop == 2'd0) begin
        w_buf0_next = data_read;
      end else begin
        w_buf1_next = data_read;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_idx       <= '0;
      r_pkt_count <= '0;
    end else begin
      r_occ      <= w_occ_next[1:0];
      r_inflight <= read_enable;
      r_buf0     <= w_buf0_next;
      r_buf1     <= w_buf1_next;
      if (w_pop) begin
        if (r_idx == C_IDX_LAST) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
        if (m_last) begin
          r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  a_occ_max : assert property (@(posedge rclk) disable iff (!rrst_n) w_occ_next <= 3'd2);

endmodule
`default_nettype wire
